// File: rtl/gray_xcode_pkg.sv
// Shared types and pure conversion helpers for the Gray transcoder block.
package gray_xcode_pkg;

    // Conversion direction carried alongside each request and result.
    typedef enum logic {
        BIN2GRAY = 1'b0,
        GRAY2BIN = 1'b1
    } dir_e;

    // Widest code word the helpers handle; narrower words are zero-extended.
    // Zero-extension is harmless for both directions: the extra high bits
    // stay zero and never fold into the low WIDTH bits.
    localparam int MAX_W = 64;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // g = b ^ (b >> 1), written as a concatenation to keep widths exact.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ {1'b0, b[MAX_W-1:1]};
    endfunction

    // Prefix XOR from the MSB down: b[j] = b[j+1] ^ g[j].
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int j = MAX_W - 2; j >= 0; j--) begin
            b[j] = b[j+1] ^ g[j];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_xcode_unit.sv
// Standalone combinational binary/Gray converter selected by direction.
module gray_xcode_unit
    import gray_xcode_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_result
);

    logic [MAX_W-1:0] w_ext;
    logic [MAX_W-1:0] w_b2g;
    logic [MAX_W-1:0] w_g2b;
    logic             w_unused_hi;

    assign w_ext  = MAX_W'(i_data);
    assign w_b2g  = bin2gray(w_ext);
    assign w_g2b  = gray2bin(w_ext);

    // High bits of the widened results are always zero and carry no information.
    assign w_unused_hi = ^{w_b2g[MAX_W-1:WIDTH], w_g2b[MAX_W-1:WIDTH]};

    // Pick the converted word for the requested direction.
    always_comb begin
        o_result = '0;
        case (dir_e'(i_dir))
            BIN2GRAY: o_result = w_b2g[WIDTH-1:0];
            GRAY2BIN: o_result = w_g2b[WIDTH-1:0];
            default:  o_result = w_b2g[WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/gray_xcode_arbiter.sv
// Round-robin shared binary/Gray transcoder with a single-entry result slot.
module gray_xcode_arbiter
    import gray_xcode_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_REQ-1:0]            i_req_valid,
    input  logic [N_REQ-1:0]            i_req_dir,
    input  logic [N_REQ-1:0][WIDTH-1:0] i_req_data,
    output logic [N_REQ-1:0]            o_req_ready,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic [ID_W-1:0]             o_rsp_id,
    output logic                        o_rsp_dir,
    output logic [WIDTH-1:0]            o_rsp_data
);

    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic              r_rsp_dir;
    logic [WIDTH-1:0]  r_rsp_data;
    logic [ID_W-1:0]   r_rr_ptr;

    logic              w_slot_free;
    logic [N_REQ-1:0]  w_grant;
    logic              w_grant_any;
    logic [ID_W-1:0]   w_grant_idx;
    int                w_sum;
    int                w_idx;
    logic [WIDTH-1:0]  w_sel_data;
    logic              w_sel_dir;
    logic [WIDTH-1:0]  w_conv;

    // The slot can take a new result when empty or when it drains this cycle.
    assign w_slot_free = !r_rsp_valid || i_rsp_ready;

    // Round-robin search starting at r_rr_ptr; first valid requester wins.
    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_sum       = 0;
        w_idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = int'(r_rr_ptr) + k;
            w_idx = (w_sum >= N_REQ) ? (w_sum - N_REQ) : w_sum;
            if (w_slot_free && !w_grant_any && i_req_valid[w_idx]) begin
                w_grant_any    = 1'b1;
                w_grant_idx    = ID_W'(w_idx);
                w_grant[w_idx] = 1'b1;
            end else begin
                w_grant_any = w_grant_any;
            end
        end
    end

    assign o_req_ready = w_grant;
    assign w_sel_data  = i_req_data[w_grant_idx];
    assign w_sel_dir   = i_req_dir[w_grant_idx];

    gray_xcode_unit #(
        .WIDTH (WIDTH)
    ) u_conv (
        .i_data   (w_sel_data),
        .i_dir    (w_sel_dir),
        .o_result (w_conv)
    );

    // Output slot and round-robin pointer: load on grant, drain on consumer ready.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_dir   <= 1'b0;
            r_rsp_data  <= '0;
            r_rr_ptr    <= '0;
        end else if (w_grant_any) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_grant_idx;
            r_rsp_dir   <= w_sel_dir;
            r_rsp_data  <= w_conv;
            r_rr_ptr    <= (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : (w_grant_idx + ID_W'(1));
        end else if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= r_rsp_valid;
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_dir   = r_rsp_dir;
    assign o_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_gray_xcode_arbiter.sv
// Directed self-checking bench for gray_xcode_arbiter (N_REQ=4, WIDTH=8).
module tb_gray_xcode_arbiter;

    logic            clk;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0]      req_dir;
    logic [3:0][7:0] req_data;
    logic [3:0]      req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic            rsp_dir;
    logic [7:0]      rsp_data;

    int n_checks = 0;
    int n_errors = 0;

    gray_xcode_arbiter #(
        .N_REQ (4),
        .WIDTH (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_dir   (req_dir),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_dir   (rsp_dir),
        .o_rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference converters written independently of the RTL helpers.
    function automatic logic [7:0] m_b2g(input logic [7:0] b);
        return b ^ {1'b0, b[7:1]};
    endfunction

    function automatic logic [7:0] m_g2b(input logic [7:0] g);
        logic [7:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transfer from requester id; called and returns at posedge+1.
    task automatic xfer(input int id, input logic dir, input logic [7:0] data, input logic [7:0] exp);
        req_valid      = 4'b0000;
        req_valid[id]  = 1'b1;
        req_dir[id]    = dir;
        req_data[id]   = data;
        @(negedge clk);
        chk("xfer_grant", 32'(req_ready), 32'(4'b0001 << id));
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("xfer_valid", 32'(rsp_valid), 32'd1);
        chk("xfer_id", 32'(rsp_id), 32'(id));
        chk("xfer_dir", 32'(rsp_dir), 32'(dir));
        chk("xfer_data", 32'(rsp_data), 32'(exp));
        tick();
    endtask

    logic [7:0] g_cur;
    logic [7:0] g_prev;
    logic [7:0] g_first;

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_dir   = 4'b0000;
        req_data  = '0;
        rsp_ready = 1'b0;
        g_cur     = 8'h00;
        g_prev    = 8'h00;
        g_first   = 8'h00;

        // Reset state
        #2;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_dir", 32'(rsp_dir), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        tick();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        tick();

        // Basic conversions through requester 0
        xfer(0, 1'b0, 8'h2D, 8'h3B);
        xfer(0, 1'b1, 8'h3B, 8'h2D);
        xfer(0, 1'b0, 8'hFF, 8'h80);

        // Exhaustive round trip through requester 2 plus single-bit adjacency
        for (int v = 0; v < 256; v++) begin
            xfer(2, 1'b0, 8'(v), m_b2g(8'(v)));
            g_cur = rsp_data;
            if (v == 0) begin
                g_first = g_cur;
            end else begin
                chk("adjacent_1bit", 32'($countones(g_cur ^ g_prev)), 32'd1);
            end
            g_prev = g_cur;
            xfer(2, 1'b1, g_cur, 8'(v));
        end
        chk("adjacent_wrap", 32'($countones(g_prev ^ g_first)), 32'd1);

        // Round-robin fairness from reset with all four requesting
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_dir   = 4'b0000;
        req_data  = {8'h33, 8'hC4, 8'h5A, 8'h91};
        req_valid = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            if (k > 0) begin
                chk("rr_valid", 32'(rsp_valid), 32'd1);
                chk("rr_id", 32'(rsp_id), 32'((k - 1) % 4));
                chk("rr_data", 32'(rsp_data), 32'(m_b2g(req_data[(k - 1) % 4])));
            end
            tick();
        end

        // Only requesters 1 and 3 active: alternate 1,3,1,3
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_grant", 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
            chk("alt_id", 32'(rsp_id), (k % 2 == 1) ? 32'd1 : 32'd3);
            tick();
        end

        // Backpressure: slot holds {id=2, data=3B}, consumer stalls 5 cycles
        req_valid   = 4'b0100;
        req_dir[2]  = 1'b0;
        req_data[2] = 8'h2D;
        @(negedge clk);
        chk("bp_load_grant", 32'(req_ready), 32'h4);
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd2);
            chk("bp_data", 32'(rsp_data), 32'h3B);
            chk("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 32'(req_ready), 32'h8);
        chk("bp_release_id", 32'(rsp_id), 32'd2);
        tick();
        @(negedge clk);
        chk("bp_reload_id", 32'(rsp_id), 32'd3);
        chk("bp_reload_data", 32'(rsp_data), 32'(m_b2g(req_data[3])));
        chk("bp_next_grant", 32'(req_ready), 32'h1);
        tick();
        @(negedge clk);
        chk("pre_rst_grant", 32'(req_ready), 32'h2);
        tick();

        // Reset mid-operation: rsp_valid=1 and rr_ptr=2 here
        req_valid = 4'b0000;
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_id", 32'(rsp_id), 32'd0);
        req_valid = 4'b1111;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", 32'(req_ready), 32'h1);
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        tick();

        // Sparse: lone requester 3, result pulses one cycle, pointer wraps to 0
        req_valid   = 4'b1000;
        req_dir[3]  = 1'b1;
        req_data[3] = 8'hA5;
        @(negedge clk);
        chk("sparse_grant", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("sparse_valid", 32'(rsp_valid), 32'd1);
        chk("sparse_id", 32'(rsp_id), 32'd3);
        chk("sparse_dir", 32'(rsp_dir), 32'd1);
        chk("sparse_data", 32'(rsp_data), 32'hC6);
        tick();
        @(negedge clk);
        chk("sparse_drop", 32'(rsp_valid), 32'd0);
        req_valid = 4'b1111;
        #1;
        chk("wrap_grant", 32'(req_ready), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
